// File: rtl/final_cpa_pipe.sv
// final_cpa_pipe: two-stage carry-propagate adder that resolves a redundant
// sum/carry pair into {ovf, prod} = s_vec + c_vec, with valid/ready
// handshakes on both sides.
//
// Optional feature macro: CPA_SKID_EN. When defined, a one-entry input skid
// buffer is added. in_ready then comes from a register, so there is no
// combinational path from out_ready to in_ready, and capacity grows from
// 2 to 3 pairs.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_vec, c_vec        redundant sum / carry vectors (PW bits, weight-aligned)
//   in_valid, in_ready  input handshake
//   prod, ovf           resolved result and carry out of bit PW-1
//   out_valid, out_ready output handshake
module final_cpa_pipe #(
  parameter int PW = 32,
  parameter int LO = PW/2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] s_vec,
  input  logic [PW-1:0] c_vec,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] prod,
  output logic          ovf,
  output logic          out_valid,
  input  logic          out_ready
);
  localparam int HI = PW - LO;

  logic          v1, v2, ld1, ld2;
  logic [LO-1:0] lo_sum;
  logic          lo_cy;
  logic [HI-1:0] s_hi, c_hi;

  // Source feeding stage 1: either the live input or the parked skid entry.
  logic          src_valid;
  logic [PW-1:0] src_s, src_c;

  // Stage 2 frees up when empty or draining; stage 1 when empty or moving on.
  // An empty stage loads even if a later stage is stalled.
  assign ld2 = ~v2 | out_ready;
  assign ld1 = ~v1 | ld2;

`ifdef CPA_SKID_EN
  logic          skid_valid;
  logic [PW-1:0] skid_s, skid_c;
  logic          acc;

  // Registered ready; forced low while reset is held.
  assign in_ready = rst_n & ~skid_valid;
  assign acc      = in_valid & in_ready;

  // A parked pair always goes first; while parked, in_ready is 0 so no
  // newer pair can be accepted ahead of it.
  always_comb begin
    src_valid = acc;
    src_s     = s_vec;
    src_c     = c_vec;
    if (skid_valid) begin
      src_valid = 1'b1;
      src_s     = skid_s;
      src_c     = skid_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_s     <= '0;
      skid_c     <= '0;
    end else if (skid_valid) begin
      if (ld1) skid_valid <= 1'b0;
    end else if (acc && !ld1) begin
      skid_valid <= 1'b1;
      skid_s     <= s_vec;
      skid_c     <= c_vec;
    end
  end
`else
  assign in_ready  = rst_n & ld1;
  assign src_valid = in_valid & in_ready;
  assign src_s     = s_vec;
  assign src_c     = c_vec;
`endif

  // Lower-half add, carry kept as the extra MSB.
  logic [LO:0] lo_add;
  assign lo_add = {1'b0, src_s[LO-1:0]} + {1'b0, src_c[LO-1:0]};

  // Upper-half add absorbs the stage-1 carry; its MSB is the final carry out.
  logic [HI:0] hi_add;
  assign hi_add = {1'b0, s_hi} + {1'b0, c_hi} + {{HI{1'b0}}, lo_cy};

  // Stage 1: data moves only with valid data; a bubble just clears v1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      lo_sum <= '0;
      lo_cy  <= 1'b0;
      s_hi   <= '0;
      c_hi   <= '0;
    end else if (ld1) begin
      v1 <= src_valid;
      if (src_valid) begin
        lo_sum <= lo_add[LO-1:0];
        lo_cy  <= lo_add[LO];
        s_hi   <= src_s[PW-1:LO];
        c_hi   <= src_c[PW-1:LO];
      end
    end
  end

  // Stage 2: holds prod/ovf steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      prod <= '0;
      ovf  <= 1'b0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        prod <= {hi_add[HI-1:0], lo_sum};
        ovf  <= hi_add[HI];
      end
    end
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_final_cpa_pipe.sv
// Scoreboard bench for final_cpa_pipe (PW=32). The driver pushes the
// expected {ovf,prod} when a pair is accepted; a negedge monitor pops and
// compares on every output transfer and checks in_ready against occupancy.
module tb_final_cpa_pipe;
`ifdef CPA_SKID_EN
  localparam int CAP  = 3;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = 2;
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_vec = '0, c_vec = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] prod;
  logic        ovf;
  logic        out_valid;
  logic        out_ready = 1'b0;

  final_cpa_pipe #(.PW(32)) dut (
    .clk(clk), .rst_n(rst_n), .s_vec(s_vec), .c_vec(c_vec),
    .in_valid(in_valid), .in_ready(in_ready), .prod(prod), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0;
  int          pops = 0, stalls = 0, occ = 0;
  bit          rnd_rdy = 1'b0;
  logic [32:0] q[$];

  task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: decisions made mid-cycle, transfers happen at the next posedge.
  always @(negedge clk) begin
    logic [32:0] e;
    bit xin, xout;
    if (!rst_n) begin
      q.delete();
      occ = 0;
    end else begin
      xin  = in_valid && in_ready;
      xout = out_valid && out_ready;
      if (occ == CAP && (SKID || !out_ready)) chk("ready_when_full", {32'd0, in_ready}, 33'd0);
      if (xout) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output got=%h exp=none t=%0t", {ovf, prod}, $time);
        end else begin
          e = q.pop_front();
          if ({ovf, prod} !== e) begin
            bad++;
            $display("FAIL scoreboard got=%h exp=%h t=%0t", {ovf, prod}, e, $time);
          end
        end
        pops++;
      end
      occ = occ + int'(xin) - int'(xout);
    end
  end

  // Random out_ready driver, active only when enabled.
  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Offer one pair until accepted; called and returns at posedge+1.
  task automatic send(input logic [31:0] s, input logic [31:0] c);
    int tries = 0;
    bit done = 1'b0;
    logic [32:0] e;
    s_vec = s; c_vec = c; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e = {1'b0, s} + {1'b0, c};
        q.push_back(e);
        done = 1'b1;
      end else begin
        stalls++;
        tries++;
      end
      @(posedge clk); #1;
      if (!done && tries > 200) begin
        total++; bad++;
        $display("FAIL send_timeout got=stalled exp=accept t=%0t", $time);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Send into an empty pipe with out_ready=1 and check 2-cycle latency and
  // a hand-computed result.
  task automatic send_chk(input string name, input logic [31:0] s, input logic [31:0] c,
                          input logic [31:0] ep, input logic eo);
    out_ready = 1'b1;
    send(s, c);
    @(negedge clk);
    chk({name, "_early"}, {32'd0, out_valid}, 33'd0);
    @(negedge clk);
    chk({name, "_valid"}, {32'd0, out_valid}, 33'd1);
    chk(name, {ovf, prod}, {eo, ep});
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {1'b0, 32'(q.size())}, 33'd0);
  endtask

  initial begin
    int idx, acc_cnt, p0, st0;
    bit stale;
    logic [31:0] a, b;

    // Reset state.
    @(negedge clk);
    chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("rst_prod_ovf", {ovf, prod}, 33'd0);
    chk("rst_in_ready", {32'd0, in_ready}, 33'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {32'd0, in_ready}, 33'd1);
    @(posedge clk); #1;

    // Directed vectors with latency checks.
    send_chk("basic",     32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0);
    send_chk("overflow",  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
    send_chk("msb_pair",  32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
    send_chk("cross_mid", 32'h0000FFFF, 32'hFFFF0001, 32'h00000000, 1'b1);
    send_chk("plain",     32'h12345678, 32'h11111111, 32'h23456789, 1'b0);
    send_chk("zero",      32'h00000000, 32'h00000000, 32'h00000000, 1'b0);

    // Backpressure: offer (k,2k) with out_ready=0 for 6 cycles.
    out_ready = 1'b0;
    idx = 1; acc_cnt = 0;
    repeat (6) begin
      s_vec = 32'(idx); c_vec = 32'(2 * idx); in_valid = (idx <= 4);
      @(negedge clk);
      if (out_valid) chk("bp_hold", {ovf, prod}, 33'd3);
      if (in_valid && in_ready) begin
        q.push_back({1'b0, s_vec} + {1'b0, c_vec});
        idx++; acc_cnt++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", {1'b0, 32'(acc_cnt)}, 33'(CAP));
    out_ready = 1'b1;
    while (idx <= 4) begin
      send(32'(idx), 32'(2 * idx));
      idx++;
    end
    drain("bp_drain");

    // Full throughput: 100 back-to-back pairs, out_ready held 1.
    out_ready = 1'b1;
    p0 = pops; st0 = stalls;
    for (int i = 0; i < 100; i++) begin
      a = $urandom; b = $urandom;
      send(a, b);
    end
    @(posedge clk); @(negedge clk); #1;
    chk("tput_stalls", {1'b0, 32'(stalls - st0)}, 33'd0);
    chk("tput_results", {1'b0, 32'(pops - p0)}, 33'd100);
    @(posedge clk); #1;

    // Random valid/ready toggling.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      a = $urandom; b = $urandom;
      if (i % 7 == 0) a = 32'hFFFFFFFF;
      send(a, b);
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    drain("rand_drain");

    // Reset mid-stream with a full pipe.
    out_ready = 1'b0;
    send(32'h00000005, 32'h00000007);
    send(32'h00000009, 32'h0000000B);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {32'd0, out_valid}, 33'd0);
    chk("mid_rst_prod", {ovf, prod}, 33'd0);
    chk("mid_rst_ready", {32'd0, in_ready}, 33'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ready3", {32'd0, in_ready}, 33'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_rel_ready", {32'd0, in_ready}, 33'd1);
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("no_stale", {32'd0, stale}, 33'd0);
    @(posedge clk); #1;

    // Pipe still works after reset.
    send_chk("post_rst", 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/final_cpa_pipe.md
FINAL_CPA_PIPE -- requirements
Module: final_cpa_pipe

Interface
REQ-001 SHALL have parameter PW, default 32, meaning product width in bits, even, at least 4.
REQ-002 SHALL have parameter LO, fixed at PW/2, meaning lower-half split point.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port s_vec, input, PW bits: redundant sum vector from the compressor tree.
REQ-006 SHALL have port c_vec, input, PW bits: redundant carry vector, already weight-aligned.
REQ-007 SHALL have port in_valid, input, 1 bit: s_vec/c_vec hold a valid pair.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts the pair this cycle.
REQ-009 SHALL have port prod, output, PW bits: resolved result.
REQ-010 SHALL have port ovf, output, 1 bit: carry out of bit PW-1 of the addition.
REQ-011 SHALL have port out_valid, output, 1 bit: prod/ovf valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-013 SHALL compute {ovf,prod} = s_vec + c_vec, (PW+1)-bit unsigned, as a two-stage carry-propagate adder.
REQ-014 Stage 1 SHALL register: lower sum s_vec[LO-1:0]+c_vec[LO-1:0] (LO bits), its carry, s_vec/c_vec upper halves, and valid bit v1.
REQ-015 Stage 2 SHALL register: upper halves + stage-1 carry, concatenated with lower sum, into prod/ovf, and valid bit v2.
REQ-016 Transfer SHALL occur on a side only when valid and ready are both 1 at a clock edge.
REQ-017 Latency SHALL be 2 cycles from input transfer to out_valid=1 when out_ready is held 1.
REQ-018 Throughput SHALL be one transfer per cycle with out_ready held 1.
REQ-019 Stage 2 SHALL load when !v2 or out_ready; stage 1 SHALL load when !v1 or stage 2 loads.
REQ-020 Bubbles SHALL collapse: an empty stage loads even while a later stage is stalled.
REQ-021 Without CPA_SKID_EN, in_ready SHALL equal the stage-1 load condition (combinational).
REQ-022 out_valid SHALL equal v2; prod/ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous output drain and input accept on a full pipeline SHALL lose no data and SHALL duplicate no data.
REQ-024 Results SHALL leave in input order; the block SHALL hold at most 2 pairs without the macro.
REQ-025 Stage data registers SHALL load only when their stage loads with valid data; bubbles SHALL clear valid bits and SHALL leave data untouched.

Reset
REQ-026 rst_n=0 SHALL immediately clear v1, v2, and any skid-valid bit, and SHALL drive out_valid=0, prod=0, ovf=0.
REQ-027 While rst_n=0, in_ready SHALL be 0.
REQ-028 The first cycle after rst_n deasserts SHALL show in_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight pairs; none SHALL appear after release.

Configuration
REQ-030 Macro CPA_SKID_EN SHALL, when defined, add a one-entry input skid buffer.
REQ-031 With CPA_SKID_EN, in_ready SHALL be a registered signal, equal to !skid_valid.
REQ-032 With CPA_SKID_EN, a pair accepted while stage 1 cannot load SHALL park in the skid buffer.
REQ-033 With CPA_SKID_EN, a parked pair SHALL enter stage 1 before any newer pair.
REQ-034 With CPA_SKID_EN, capacity SHALL be 3 pairs, and no combinational path SHALL exist from out_ready to in_ready.
REQ-035 Without CPA_SKID_EN, no skid storage SHALL exist, and latency/throughput SHALL be identical in the unstalled case.

Verification
REQ-036 Reset: rst_n=0 for 3 cycles mid-stream -> out_valid=0, prod=0, ovf=0, in_ready=0; after release, no stale outputs appear.
REQ-037 Basic (PW=32): s=0x0000FFFF, c=0x00000001, out_ready=1 -> prod=0x00010000, ovf=0, exactly 2 cycles after accept.
REQ-038 Overflow: s=0xFFFFFFFF, c=0x00000001 -> prod=0x00000000, ovf=1.
REQ-039 Backpressure: stream 4 pairs (k, 2k) for k=1..4 with out_ready=0 -> in_ready drops after 2 accepts (3 with CPA_SKID_EN); prod stays held. Release out_ready -> outputs 3, 6, 9, 12 in order, no loss or duplicates.
REQ-040 Full-throughput: 100 random pairs with in_valid=out_ready=1 -> one result per cycle, each matching s+c mod 2^32 with correct ovf.
REQ-041 Random valid/ready toggling, 1000 pairs, scoreboard compare -> zero mismatches; in_ready never 1 while storage is full.
